// File: rtl/mpu_elementwise_if.sv
// Handshake and matrix bus between a requester (master) and the element-wise matrix unit (slave).
interface mpu_elementwise_if #(
  parameter int ELEM_W = 8,
  parameter int DIM    = 5
);
  logic                        start;
  logic                        op_sub;
  logic                        sat_en;
  logic                        signed_en;
  logic [ELEM_W*DIM*DIM-1:0]   matrix_a;
  logic [ELEM_W*DIM*DIM-1:0]   matrix_b;
  logic                        busy;
  logic                        done;
  logic [ELEM_W*DIM*DIM-1:0]   result;
  logic                        overflow;

  modport master (
    output start, op_sub, sat_en, signed_en, matrix_a, matrix_b,
    input  busy, done, result, overflow
  );

  modport slave (
    input  start, op_sub, sat_en, signed_en, matrix_a, matrix_b,
    output busy, done, result, overflow
  );
endinterface

// File: rtl/mpu_elementwise.sv
// Element-wise add/sub of two DIMxDIM matrices, one row per cycle; done pulses DIM+1 edges after start.
// start is ignored while busy; operands and modes are captured on the accepted start.
module mpu_elementwise #(
  parameter int ELEM_W = 8,
  parameter int DIM    = 5
) (
  input  logic             clk,
  input  logic             rst,
  mpu_elementwise_if.slave bus
);
  localparam int N     = DIM * DIM;
  localparam int ROW_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(DIM - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q;
  logic [ROW_W-1:0]        row_q;
  logic [ELEM_W*N-1:0]     a_q;
  logic [ELEM_W*N-1:0]     b_q;
  logic [ELEM_W*N-1:0]     result_q;
  logic [ELEM_W*N-1:0]     result_d;
  logic                    op_sub_q;
  logic                    sat_en_q;
  logic                    signed_en_q;
  logic                    done_q;
  logic                    overflow_q;
  logic                    overflow_d;
  logic [DIM-1:0][ELEM_W:0] row_r;

  // Returns {overflow, value}; the extra bit makes the exact result representable.
  function automatic logic [ELEM_W:0] elem_op(
    input logic [ELEM_W-1:0] a,
    input logic [ELEM_W-1:0] b,
    input logic              sub,
    input logic              sat,
    input logic              sgn
  );
    logic [ELEM_W:0]   ea;
    logic [ELEM_W:0]   eb;
    logic [ELEM_W:0]   s;
    logic              ovf;
    logic [ELEM_W-1:0] v;
    ea  = {sgn & a[ELEM_W-1], a};
    eb  = {sgn & b[ELEM_W-1], b};
    s   = sub ? (ea - eb) : (ea + eb);
    ovf = sgn ? (s[ELEM_W] ^ s[ELEM_W-1]) : s[ELEM_W];
    v   = s[ELEM_W-1:0];
    if (sat && ovf) begin
      if (sgn) begin
        v = s[ELEM_W] ? {1'b1, {(ELEM_W-1){1'b0}}} : {1'b0, {(ELEM_W-1){1'b1}}};
      end else begin
        v = sub ? '0 : '1;
      end
    end
    return {ovf, v};
  endfunction

  always_comb begin
    row_r      = '0;
    result_d   = result_q;
    overflow_d = overflow_q;
    for (int j = 0; j < DIM; j++) begin
      row_r[j] = elem_op(a_q[ELEM_W*(int'(row_q) + DIM*j) +: ELEM_W],
                         b_q[ELEM_W*(int'(row_q) + DIM*j) +: ELEM_W],
                         op_sub_q, sat_en_q, signed_en_q);
      result_d[ELEM_W*(int'(row_q) + DIM*j) +: ELEM_W] = row_r[j][ELEM_W-1:0];
      overflow_d = overflow_d | row_r[j][ELEM_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_sub_q    <= 1'b0;
      sat_en_q    <= 1'b0;
      signed_en_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q         <= bus.matrix_a;
            b_q         <= bus.matrix_b;
            op_sub_q    <= bus.op_sub;
            sat_en_q    <= bus.sat_en;
            signed_en_q <= bus.signed_en;
            overflow_q  <= 1'b0;
            row_q       <= '0;
            state_q     <= RUN;
          end
        end
        RUN: begin
          result_q   <= result_d;
          overflow_q <= overflow_d;
          if (row_q == LAST_ROW) begin
            row_q   <= '0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            row_q <= row_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_mpu_elementwise.sv
// Randomized and directed bench for mpu_elementwise against an integer-arithmetic reference.
module tb_mpu_elementwise;
  localparam int W  = 8;
  localparam int D  = 5;
  localparam int N  = D * D;
  localparam int NB = W * N;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mpu_elementwise_if #(.ELEM_W(W), .DIM(D)) bus ();

  mpu_elementwise #(.ELEM_W(W), .DIM(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] el(input logic [NB-1:0] m, input int k);
    return m[W*k +: W];
  endfunction

  // Exact integer result, then range check and clamp or truncate.
  function automatic logic [W:0] ref_elem(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input bit sub, input bit sat, input bit sgn);
    int av, bv, ex, lo, hi;
    bit o;
    av = int'(a);
    bv = int'(b);
    if (sgn && a[W-1]) av -= (1 << W);
    if (sgn && b[W-1]) bv -= (1 << W);
    ex = sub ? av - bv : av + bv;
    lo = sgn ? -(1 << (W-1)) : 0;
    hi = sgn ? (1 << (W-1)) - 1 : (1 << W) - 1;
    o  = (ex < lo) || (ex > hi);
    if (sat && ex < lo) ex = lo;
    else if (sat && ex > hi) ex = hi;
    return {o, W'(ex)};
  endfunction

  function automatic logic [NB:0] ref_mat(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                          input bit sub, input bit sat, input bit sgn);
    logic [NB-1:0] r;
    logic [W:0]    e;
    bit            o;
    r = '0;
    o = 1'b0;
    for (int k = 0; k < N; k++) begin
      e = ref_elem(a[W*k +: W], b[W*k +: W], sub, sat, sgn);
      r[W*k +: W] = e[W-1:0];
      o = o | e[W];
    end
    return {o, r};
  endfunction

  function automatic logic [W-1:0] rnd_el();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return {1'b0, {(W-1){1'b1}}};
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  // Drives one operation, tracks latency/busy, checks result and flags against the model.
  task automatic run_op(input string tag, input logic [NB-1:0] a, input logic [NB-1:0] b,
                        input bit sub, input bit sat, input bit sgn, input bit disturb);
    logic [NB:0] exp;
    int lat, busy_cnt;
    exp = ref_mat(a, b, sub, sat, sgn);
    @(negedge clk);
    bus.matrix_a  = a;
    bus.matrix_b  = b;
    bus.op_sub    = sub;
    bus.sat_en    = sat;
    bus.signed_en = sgn;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat      = 0;
    busy_cnt = bus.busy ? 1 : 0;
    while (!bus.done && lat < 4*D) begin
      @(negedge clk);
      lat++;
      if (bus.busy) busy_cnt++;
      if (disturb && lat == 1) begin
        bus.start     = 1'b1;
        bus.matrix_a  = ~a;
        bus.op_sub    = ~sub;
        bus.sat_en    = ~sat;
      end
      if (disturb && lat == 2) bus.start = 1'b0;
    end
    chk({tag, "_latency"}, lat, D);
    chk({tag, "_busy_cycles"}, busy_cnt, D);
    chk({tag, "_busy_at_done"}, bus.busy, 0);
    chk({tag, "_result"}, bus.result, exp[NB-1:0]);
    chk({tag, "_overflow"}, bus.overflow, exp[NB]);
    @(negedge clk);
    chk({tag, "_done_pulse"}, bus.done, 0);
    chk({tag, "_result_hold"}, bus.result, exp[NB-1:0]);
  endtask

  initial begin
    logic [NB-1:0] a, b;
    logic [NB:0]   exp;
    int            ndone, nlow, prev, cnt, lat;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.op_sub = 1'b0; bus.sat_en = 1'b0; bus.signed_en = 1'b0;
    bus.matrix_a = '0; bus.matrix_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_result", bus.result, 0);
    chk("reset_overflow", bus.overflow, 0);
    rst = 1'b0;

    for (int k = 0; k < N; k++) begin
      a[W*k +: W] = W'(k + 1);
      b[W*k +: W] = W'(25 - k);
    end
    run_op("u_wrap_sub", a, b, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("u_wrap_sub_e0", el(bus.result, 0), 232);
    chk("u_wrap_sub_e12", el(bus.result, 12), 0);
    chk("u_wrap_sub_e24", el(bus.result, 24), 24);
    chk("u_wrap_sub_ovf", bus.overflow, 1);

    run_op("u_sat_sub", a, b, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("u_sat_sub_e0", el(bus.result, 0), 0);
    chk("u_sat_sub_e12", el(bus.result, 12), 0);
    chk("u_sat_sub_e13", el(bus.result, 13), 2);
    chk("u_sat_sub_e24", el(bus.result, 24), 24);

    for (int k = 0; k < N; k++) begin
      a[W*k +: W] = 8'd100;
      b[W*k +: W] = 8'd50;
    end
    run_op("s_sat_add", a, b, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("s_sat_add_e7", el(bus.result, 7), 127);
    chk("s_sat_add_ovf", bus.overflow, 1);
    run_op("s_wrap_add", a, b, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("s_wrap_add_e3", el(bus.result, 3), 8'h96);

    for (int k = 0; k < N; k++) begin
      a[W*k +: W] = 8'h80;
      b[W*k +: W] = 8'h01;
    end
    run_op("s_sat_sub", a, b, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("s_sat_sub_e0", el(bus.result, 0), 8'h80);
    chk("s_sat_sub_e24", el(bus.result, 24), 8'h80);

    for (int k = 0; k < N; k++) begin
      a[W*k +: W] = W'(k + 1);
      b[W*k +: W] = W'(k + 1);
    end
    run_op("u_wrap_add_dist", a, b, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("u_wrap_add_e10", el(bus.result, 10), 22);
    chk("u_wrap_add_ovf", bus.overflow, 0);

    // Back-to-back operations with start held high.
    for (int k = 0; k < N; k++) begin
      a[W*k +: W] = rnd_el();
      b[W*k +: W] = rnd_el();
    end
    exp = ref_mat(a, b, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    bus.matrix_a = a; bus.matrix_b = b;
    bus.op_sub = 1'b0; bus.sat_en = 1'b1; bus.signed_en = 1'b0;
    bus.start = 1'b1;
    ndone = 0; nlow = 0; prev = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        if (prev < 0) chk("b2b_first_done", c, D);
        else chk("b2b_gap", c - prev, D + 1);
        prev = c;
      end
      if (!bus.busy) nlow++;
    end
    bus.start = 1'b0;
    chk("b2b_done_count", ndone, 3);
    chk("b2b_busy_low_count", nlow, 3);
    lat = 0;
    while (!bus.done && lat < 4*D) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_tail_done", bus.done, 1);
    chk("b2b_result", bus.result, exp[NB-1:0]);
    chk("b2b_overflow", bus.overflow, exp[NB]);
    @(negedge clk);

    // Reset in the middle of a run.
    for (int k = 0; k < N; k++) begin
      a[W*k +: W] = rnd_el();
      b[W*k +: W] = rnd_el();
    end
    bus.matrix_a = a; bus.matrix_b = b; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_run_busy", bus.busy, 0);
    chk("rst_run_done", bus.done, 0);
    chk("rst_run_result", bus.result, 0);
    chk("rst_run_overflow", bus.overflow, 0);
    rst = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
    chk("rst_run_no_done", cnt, 0);
    run_op("after_rst", a, b, 1'b1, 1'b0, 1'b1, 1'b0);

    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < N; k++) begin
        a[W*k +: W] = rnd_el();
        b[W*k +: W] = rnd_el();
      end
      run_op($sformatf("rand%0d", t), a, b, 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
